// File: rtl/arashi_pkg.sv
// arashi_pkg: shared op/ctrl encodings and ctrl lane helper for the arashi thread driver and decoder
package arashi_pkg;
  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_READ = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b10;
  localparam int CTRL_W_BIT = 1;
  localparam int CTRL_R_BIT = 0;
  function automatic logic [1:0] ctrl_lane(input logic [31:0] ctrl, input int i);
    return ctrl[2*i +: 2];
  endfunction
endpackage

// File: rtl/arashi_thread_driver_if.sv
// arashi_thread_driver_if: host cmd (valid/ready/tid/op/data) and rsp (valid/ready/tid/data) streams; master=host, slave=driver
interface arashi_thread_driver_if #(
  parameter int DATA_WIDTH = 32,
  parameter int THREAD_NUM_WIDTH = 2
);
  logic cmd_valid;
  logic cmd_ready;
  logic [THREAD_NUM_WIDTH-1:0] cmd_tid;
  logic [1:0] cmd_op;
  logic [DATA_WIDTH-1:0] cmd_data;
  logic rsp_valid;
  logic rsp_ready;
  logic [THREAD_NUM_WIDTH-1:0] rsp_tid;
  logic [DATA_WIDTH-1:0] rsp_data;
  modport master(
    output cmd_valid, cmd_tid, cmd_op, cmd_data, rsp_ready,
    input cmd_ready, rsp_valid, rsp_tid, rsp_data
  );
  modport slave(
    input cmd_valid, cmd_tid, cmd_op, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_tid, rsp_data
  );
endinterface

// File: rtl/arashi_sync_fifo.sv
// arashi_sync_fifo: sync FIFO (clk, rstn active-low sync; push/din in, pop in, dout/full/empty/count out)
module arashi_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rstn,
  input  logic push,
  input  logic [WIDTH-1:0] din,
  input  logic pop,
  output logic [WIDTH-1:0] dout,
  output logic full,
  output logic empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign dout = mem[rp];
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/arashi_thread_driver.sv
// arashi_thread_driver: per-thread cmd queues -> registered ctrl/wdata lanes, rdata capture -> rsp stream (clk, rstn, host if, ctrl, wdata, rdata, err, idle)
module arashi_thread_driver
  import arashi_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int THREAD_NUM_WIDTH = 2,
  parameter int CMD_DEPTH = 4,
  parameter int RSP_DEPTH = 8,
  parameter int READ_LATENCY = 1,
  localparam int TN = 1 << THREAD_NUM_WIDTH
) (
  input  logic clk,
  input  logic rstn,
  arashi_thread_driver_if.slave host,
  output logic [2*TN-1:0] ctrl,
  output logic [DATA_WIDTH*TN-1:0] wdata,
  input  logic [DATA_WIDTH*TN-1:0] rdata,
  output logic err,
  output logic idle
);
  localparam int DW = DATA_WIDTH;
  localparam int TW = THREAD_NUM_WIDTH;
  localparam int RL = READ_LATENCY;
  localparam int SW = READ_LATENCY * THREAD_NUM_WIDTH;
  localparam int CA = $clog2(CMD_DEPTH);
  localparam int RA = $clog2(RSP_DEPTH);
  localparam int CW = RA + 2;
  if (TW < 2 || TW > 4) begin : g_tw_chk
    $error("THREAD_NUM_WIDTH must be in 2..4");
  end
  if (CMD_DEPTH < 2 || (CMD_DEPTH & (CMD_DEPTH - 1)) != 0) begin : g_cd_chk
    $error("CMD_DEPTH must be a power of 2, >= 2");
  end
  if (RSP_DEPTH < 2 || (RSP_DEPTH & (RSP_DEPTH - 1)) != 0) begin : g_rd_chk
    $error("RSP_DEPTH must be a power of 2, >= 2");
  end
  if (RL < 1) begin : g_rl_chk
    $error("READ_LATENCY must be >= 1");
  end
  logic [TN-1:0] c_full, c_empty, c_pop, hd_wr, req;
  logic [DW:0] c_dout [TN];
  logic [TN-1:0][CA:0] c_cnt;
  logic [TW-1:0] rr, gnt, iss_tid, cap_tid;
  logic gnt_v, credit, issue, legal, accept, iss_v, cap;
  logic [CW-1:0] inflight;
  logic [RL-1:0] sv;
  logic [RL-1:0][TW-1:0] st;
  logic [RA:0] r_count;
  logic r_empty, r_full;
  logic [TW+DW-1:0] r_dout;
  logic unused_ok;
  assign legal = host.cmd_op == OP_READ || host.cmd_op == OP_WRITE;
  assign host.cmd_ready = !c_full[host.cmd_tid];
  assign accept = host.cmd_valid && host.cmd_ready;
  for (genvar i = 0; i < TN; i++) begin : g_t
    arashi_sync_fifo #(.WIDTH(DW + 1), .DEPTH(CMD_DEPTH)) u_cmd (
      .clk(clk),
      .rstn(rstn),
      .push(accept && legal && host.cmd_tid == TW'(i)),
      .din({host.cmd_op == OP_WRITE, host.cmd_data}),
      .pop(c_pop[i]),
      .dout(c_dout[i]),
      .full(c_full[i]),
      .empty(c_empty[i]),
      .count(c_cnt[i])
    );
    assign hd_wr[i] = !c_empty[i] && c_dout[i][DW];
    assign req[i] = !c_empty[i] && !c_dout[i][DW];
    assign c_pop[i] = hd_wr[i] || (issue && gnt == TW'(i));
  end
  // descending scan so the requester closest after rr wins
  always_comb begin
    gnt = rr;
    gnt_v = 1'b0;
    for (int k = TN - 1; k >= 0; k--)
      if (req[rr + TW'(k)]) begin
        gnt = rr + TW'(k);
        gnt_v = 1'b1;
      end
  end
  // reads in flight plus queued responses never exceed the response FIFO
  assign credit = (inflight + CW'(r_count)) < CW'(RSP_DEPTH);
  assign issue = gnt_v && credit;
  assign cap = sv[RL-1];
  assign cap_tid = st[RL-1];
  always_ff @(posedge clk) begin
    if (!rstn) begin
      ctrl <= '0;
      wdata <= '0;
      err <= 1'b0;
      rr <= '0;
      inflight <= '0;
      iss_v <= 1'b0;
      sv <= '0;
    end else begin
      err <= err | (accept && !legal);
      for (int i = 0; i < TN; i++) begin
        ctrl[2*i +: 2] <= {hd_wr[i], issue && gnt == TW'(i)};
        if (hd_wr[i]) wdata[DW*i +: DW] <= c_dout[i][DW-1:0];
      end
      if (issue) rr <= gnt + 1'b1;
      iss_v <= issue;
      sv <= RL'({sv, iss_v});
      inflight <= inflight + CW'(issue) - CW'(cap);
    end
  end
  always_ff @(posedge clk) begin
    iss_tid <= gnt;
    st <= SW'({st, iss_tid});
  end
  arashi_sync_fifo #(.WIDTH(TW + DW), .DEPTH(RSP_DEPTH)) u_rsp (
    .clk(clk),
    .rstn(rstn),
    .push(cap),
    .din({cap_tid, rdata[DW*cap_tid +: DW]}),
    .pop(host.rsp_ready),
    .dout(r_dout),
    .full(r_full),
    .empty(r_empty),
    .count(r_count)
  );
  assign host.rsp_valid = !r_empty;
  assign {host.rsp_tid, host.rsp_data} = r_dout;
  assign idle = &c_empty && inflight == '0 && r_empty;
  assign unused_ok = ^{r_full, c_cnt};
endmodule

// File: tb/tb_arashi_thread_driver.sv
// tb_arashi_thread_driver: vector table plus scoreboard bench with a latency-accurate echo target
module tb_arashi_thread_driver;
  import arashi_pkg::*;
  localparam int DW = 32;
  localparam int TW = 2;
  localparam int TN = 4;
  localparam int RL = 3;
  typedef struct packed {
    logic [TW-1:0] tid;
    logic [DW-1:0] data;
  } exp_t;
  typedef struct {
    logic [TW-1:0] tid;
    logic [1:0] op;
    logic [DW-1:0] data;
    logic [2*TN-1:0] exp_ctrl;
    logic [DW-1:0] exp_lane;
    logic exp_err;
    logic exp_idle;
  } vec_t;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic [2*TN-1:0] ctrl;
  logic [DW*TN-1:0] wdata, rdata;
  logic err, idle;
  logic [DW-1:0] treg [TN];
  logic [DW*TN-1:0] pipe [RL];
  logic [DW-1:0] exp_reg [TN];
  exp_t sb[$];
  int tid_log[$];
  int rd_lane[$];
  int rd_cyc[$];
  int n_cmp = 0;
  int n_bad = 0;
  int rsp_n = 0;
  int rd_bits = 0;
  int cyc = 0;
  vec_t tbl [9];
  always #5 clk = ~clk;
  arashi_thread_driver_if #(.DATA_WIDTH(DW), .THREAD_NUM_WIDTH(TW)) host ();
  arashi_thread_driver #(
    .DATA_WIDTH(DW), .THREAD_NUM_WIDTH(TW), .CMD_DEPTH(4), .RSP_DEPTH(8), .READ_LATENCY(RL)
  ) dut (
    .clk(clk), .rstn(rstn), .host(host), .ctrl(ctrl), .wdata(wdata), .rdata(rdata),
    .err(err), .idle(idle)
  );
  initial for (int i = 0; i < TN; i++) begin
    treg[i] = '0;
    exp_reg[i] = '0;
  end
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < TN; i++) begin
      if (ctrl[2*i+1] === 1'b1) treg[i] <= wdata[DW*i +: DW];
      else if (ctrl[2*i] === 1'b1) treg[i] <= treg[i] + 1;
      pipe[0][DW*i +: DW] <= treg[i];
    end
    for (int k = 1; k < RL; k++) pipe[k] <= pipe[k-1];
  end
  assign rdata = pipe[RL-1];
  always @(negedge clk) begin : mon
    int idx;
    if (rstn) begin
      for (int i = 0; i < TN; i++) begin
        if (ctrl_lane(32'(ctrl), i) == 2'b11) begin
          n_cmp++;
          n_bad++;
          $display("FAIL ctrl_lane%0d_11: got 2'b11 required never", i);
        end
        if (ctrl[2*i]) begin
          rd_bits++;
          rd_lane.push_back(i);
          rd_cyc.push_back(cyc);
        end
      end
      if (host.rsp_valid && host.rsp_ready) begin
        idx = -1;
        for (int j = 0; j < sb.size(); j++)
          if (idx < 0 && sb[j].tid == host.rsp_tid) idx = j;
        n_cmp++;
        if (idx < 0) begin
          n_bad++;
          $display("FAIL rsp_unexpected: got tid=%0d data=%h required no response", host.rsp_tid, host.rsp_data);
        end else begin
          if (sb[idx].data !== host.rsp_data) begin
            n_bad++;
            $display("FAIL rsp_data_t%0d: got %h required %h", host.rsp_tid, host.rsp_data, sb[idx].data);
          end
          sb.delete(idx);
        end
        rsp_n++;
        tid_log.push_back(int'(host.rsp_tid));
      end
    end
  end
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [TW-1:0] tid, input logic [1:0] op, input logic [DW-1:0] data);
    int n = 0;
    host.cmd_tid = tid;
    host.cmd_op = op;
    host.cmd_data = data;
    host.cmd_valid = 1'b1;
    #1;
    while (!host.cmd_ready && n < 200) begin
      tick();
      n++;
    end
    if (!host.cmd_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL cmd_ready_timeout t%0d: got 0 required 1", tid);
      host.cmd_valid = 1'b0;
    end else begin
      if (op == OP_READ) begin
        sb.push_back('{tid, exp_reg[tid]});
        exp_reg[tid] = exp_reg[tid] + 1;
      end else if (op == OP_WRITE) exp_reg[tid] = data;
      tick();
      host.cmd_valid = 1'b0;
    end
  endtask
  task automatic wait_idle(input string name);
    int n = 0;
    while (!idle && n < 500) begin
      tick();
      n++;
    end
    chk(name, idle, 1);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1);
  end
  initial begin : main
    int b0;
    int n0;
    tbl[0] = '{2'd0, OP_WRITE, 32'hA5A5A5A5, 8'b0000_0010, 32'hA5A5A5A5, 1'b0, 1'b1};
    tbl[1] = '{2'd1, OP_WRITE, 32'h11111111, 8'b0000_1000, 32'h11111111, 1'b0, 1'b1};
    tbl[2] = '{2'd3, OP_WRITE, 32'hDEADBEEF, 8'b1000_0000, 32'hDEADBEEF, 1'b0, 1'b1};
    tbl[3] = '{2'd2, OP_WRITE, 32'h12345678, 8'b0010_0000, 32'h12345678, 1'b0, 1'b1};
    tbl[4] = '{2'd1, OP_READ, 32'hFFFF0000, 8'b0000_0100, 32'h11111111, 1'b0, 1'b0};
    tbl[5] = '{2'd0, OP_READ, 32'h0, 8'b0000_0001, 32'hA5A5A5A5, 1'b0, 1'b0};
    tbl[6] = '{2'd3, OP_READ, 32'h0, 8'b0100_0000, 32'hDEADBEEF, 1'b0, 1'b0};
    tbl[7] = '{2'd0, 2'b11, 32'hFFFFFFFF, 8'b0000_0000, 32'hA5A5A5A5, 1'b1, 1'b1};
    tbl[8] = '{2'd2, OP_NONE, 32'h55555555, 8'b0000_0000, 32'h12345678, 1'b1, 1'b1};
    host.cmd_valid = 1'b0;
    host.cmd_tid = '0;
    host.cmd_op = OP_NONE;
    host.cmd_data = '0;
    host.rsp_ready = 1'b1;
    repeat (3) tick();
    rstn = 1'b1;
    chk("rst_ctrl", ctrl, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_rsp_valid", host.rsp_valid, 0);
    chk("rst_err", err, 0);
    chk("rst_idle", idle, 1);
    chk("rst_cmd_ready", host.cmd_ready, 1);
    for (int v = 0; v < 9; v++) begin
      send(tbl[v].tid, tbl[v].op, tbl[v].data);
      tick();
      chk($sformatf("vec%0d_ctrl", v), ctrl, tbl[v].exp_ctrl);
      chk($sformatf("vec%0d_lane", v), wdata[DW*tbl[v].tid +: DW], tbl[v].exp_lane);
      chk($sformatf("vec%0d_err", v), err, tbl[v].exp_err);
      chk($sformatf("vec%0d_idle", v), idle, tbl[v].exp_idle);
      tick();
      chk($sformatf("vec%0d_ctrl_after", v), ctrl, 0);
      wait_idle($sformatf("vec%0d_drain", v));
    end
    tid_log.delete();
    rd_lane.delete();
    rd_cyc.delete();
    send(2'd1, OP_READ, '0);
    send(2'd2, OP_READ, '0);
    send(2'd3, OP_READ, '0);
    wait_idle("t2_drain");
    chk("t2_rd_count", rd_lane.size(), 3);
    for (int j = 0; j < 3 && j < rd_lane.size(); j++) begin
      chk($sformatf("t2_rd_lane%0d", j), rd_lane[j], j + 1);
      chk($sformatf("t2_rd_cyc%0d", j), rd_cyc[j] - rd_cyc[0], j);
    end
    chk("t2_rsp_count", tid_log.size(), 3);
    for (int j = 0; j < 3 && j < tid_log.size(); j++)
      chk($sformatf("t2_rsp_tid%0d", j), tid_log[j], j + 1);
    send(2'd0, OP_WRITE, 32'h100);
    wait_idle("t3_pre_drain");
    host.rsp_ready = 1'b0;
    b0 = rd_bits;
    n0 = rsp_n;
    for (int j = 0; j < 10; j++) send(2'd0, OP_READ, '0);
    repeat (20) tick();
    chk("t3_issued_blocked", rd_bits - b0, 8);
    chk("t3_rsp_valid", host.rsp_valid, 1);
    chk("t3_idle", idle, 0);
    send(2'd2, OP_READ, '0);
    send(2'd2, OP_WRITE, 32'hC0);
    send(2'd2, OP_WRITE, 32'hC1);
    send(2'd2, OP_WRITE, 32'hC2);
    host.cmd_tid = 2'd2;
    #1;
    chk("t4_full_ready", host.cmd_ready, 0);
    tick();
    chk("t4_full_ready_hold", host.cmd_ready, 0);
    host.cmd_tid = 2'd3;
    #1;
    chk("t4_other_ready", host.cmd_ready, 1);
    send(2'd1, OP_WRITE, 32'h77);
    tick();
    chk("t4_other_write", ctrl[3:2], 2'b10);
    chk("t4_other_wdata", wdata[DW +: DW], 32'h77);
    chk("t3_still_blocked", rd_bits - b0, 8);
    host.rsp_ready = 1'b1;
    wait_idle("t3_drain");
    chk("t3_total_issued", rd_bits - b0, 11);
    chk("t3_total_rsp", rsp_n - n0, 11);
    chk("t3_sb_empty", sb.size(), 0);
    chk("t6_err_before", err, 1);
    send(2'd1, OP_READ, '0);
    send(2'd2, OP_READ, '0);
    send(2'd3, OP_READ, '0);
    tick();
    rstn = 1'b0;
    sb.delete();
    n0 = rsp_n;
    tick();
    rstn = 1'b1;
    chk("t6_ctrl", ctrl, 0);
    chk("t6_wdata", wdata, 0);
    chk("t6_err", err, 0);
    chk("t6_idle", idle, 1);
    chk("t6_rsp_valid", host.rsp_valid, 0);
    for (int j = 0; j < 8; j++) begin
      tick();
      chk($sformatf("t6_quiet_valid%0d", j), host.rsp_valid, 0);
      chk($sformatf("t6_quiet_idle%0d", j), idle, 1);
    end
    chk("t6_no_rsp", rsp_n - n0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
